debug_run_ctrl: RTL and testbench
=================================

# debug_run_ctrl

Run-mode sequencer between the UART command path and the MIPS pipeline. It turns decoded command bytes into pipeline control: continuous run, single step, abort and soft reset. It counts executed cycles and requests a debug-snapshot dump whenever execution stops. It sits beside the UART interface and drives the pipeline's stall and reset inputs.

## Interface
Parameters:
- NB_CYCLES, 32: width of the executed-cycle counter.
- MAX_CYCLES, 32'd1_000_000: watchdog limit for continuous run.
- RST_CYCLES, 4: length of the pipeline soft-reset pulse in clocks (≥1).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- i_cmd_valid  in  1  one-cycle strobe; i_cmd holds a received byte.
- i_cmd  in  8  command byte: 0x43 'C' run, 0x53 'S' step, 0x48 'H' halt, 0x52 'R' reset.
- i_end  in  1  pipeline reports program end (level).
- i_dump_done  in  1  one-cycle strobe; snapshot transmission finished.
- o_halt  out  1  1 = pipeline stalled.
- o_pipe_rst  out  1  1 = pipeline held in reset.
- o_dump_req  out  1  one-cycle request to transmit a snapshot.
- o_busy  out  1  1 when the state is not IDLE or DONE.
- o_cmd_err  out  1  one-cycle pulse on an unknown or illegal command.
- o_timeout  out  1  sticky; watchdog expired.
- o_cycle_count  out  NB_CYCLES  unhalted cycles since the last reset.
- o_state  out  3  current state encoding.

## Operation
- States and encodings:
  - IDLE=0
  - RUN=1
  - STEP=2
  - DUMP=3
  - DONE=4
  - PRST=5
- All outputs are registered. Reset values:
  - o_halt=1; o_pipe_rst=1 for RST_CYCLES cycles.
  - o_dump_req=0, o_busy=0, o_cmd_err=0, o_timeout=0.
  - o_cycle_count=0.
  - State is PRST (power-on soft reset), then IDLE.
- IDLE (o_halt=1):
  - 'C' → RUN.
  - 'S' → STEP.
  - 'R' → PRST.
  - 'H' or an unknown byte → o_cmd_err pulse; state unchanged.
- RUN (o_halt=0):
  - o_cycle_count increments on every cycle in RUN.
  - Exit to DUMP when any of these hold: i_end=1; 'H' received; o_cycle_count reaches MAX_CYCLES. On the watchdog exit, o_timeout is set.
  - Any other command while in RUN → o_cmd_err, ignored.
- STEP (o_halt=0):
  - Lasts exactly one cycle; o_cycle_count increments by 1; then → DUMP.
- DUMP (o_halt=1):
  - o_dump_req pulses on the first cycle of DUMP.
  - Wait for i_dump_done. Then → DONE if i_end=1 or o_timeout=1; otherwise → IDLE.
  - Commands during DUMP → o_cmd_err.
- DONE (o_halt=1):
  - Only 'R' is accepted, → PRST.
  - 'C' or 'S' → o_cmd_err.
- PRST (o_halt=1, o_pipe_rst=1):
  - Holds for RST_CYCLES clocks, then → IDLE.
  - Clears o_cycle_count and o_timeout.
  - Commands received during PRST → o_cmd_err.
- Counter behaviour: o_cycle_count saturates at all-ones and never wraps.
- Simultaneous events:
  - i_end and 'H' in the same RUN cycle → i_end wins (→ DUMP, later → DONE).
  - i_dump_done outside DUMP is ignored.
- Reset mid-operation:
  - Asserting i_rst in any state forces the reset values immediately.
  - A pending dump is dropped.

## Timing
- Command latency: i_cmd_valid at edge N → new state and o_halt at edge N+1.
- RUN: halt drops the cycle after the command and rises the cycle after the exit condition is sampled. Exactly k unhalted cycles are counted for k cycles in RUN.
- STEP: o_halt is low for exactly one clock.
- DUMP: o_dump_req is high exactly one clock, on the cycle DUMP is entered. i_dump_done is accepted at the earliest on the following cycle.
- PRST: o_pipe_rst is high for exactly RST_CYCLES clocks.
- Watchdog: the exit to DUMP happens on the cycle o_cycle_count equals MAX_CYCLES.

## Configuration
- RUN_WATCHDOG_EN defined:
  - MAX_CYCLES limit active.
  - o_timeout is set when the limit is hit.
- RUN_WATCHDOG_EN undefined:
  - No limit; RUN exits only on i_end or 'H'.
  - o_timeout is tied to 0.
  - The counter still saturates.

## Test plan
- Release from reset: o_pipe_rst high 4 cycles, then IDLE. 'S' → o_halt low 1 cycle, o_cycle_count=1, o_dump_req pulse. i_dump_done → IDLE.
- 'C', then i_end raised after 10 cycles → o_cycle_count=10, one o_dump_req. i_dump_done → DONE. A following 'C' → o_cmd_err; 'R' → PRST, count=0.
- 'C', then 'H' after 25 cycles → count=25, DUMP → IDLE, o_timeout=0.
- With RUN_WATCHDOG_EN and MAX_CYCLES=100: 'C' with no i_end → exit at count=100, o_timeout=1, DONE after the dump.
- i_end and 'H' in the same cycle → DONE path taken. Byte 0x41 in IDLE → o_cmd_err pulse, state stays 0.
- i_rst asserted mid-RUN at count=7 → o_halt=1, count=0, o_dump_req never pulses.

Source files
------------

// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run-mode sequencer between the UART command decoder and the
// MIPS pipeline. It turns command bytes into run/step/halt/soft-reset control,
// counts unhalted cycles and requests a snapshot dump whenever execution stops.
// Optional feature macro: RUN_WATCHDOG_EN enables the MAX_CYCLES run watchdog.
// Without it, RUN only ends on i_end or 'H' and o_timeout stays 0.
module debug_run_ctrl #(
    parameter int          NB_CYCLES  = 32,
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000,
    parameter int          RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [7:0]           i_cmd,
    input  logic                 i_end,
    input  logic                 i_dump_done,
    output logic                 o_halt,
    output logic                 o_pipe_rst,
    output logic                 o_dump_req,
    output logic                 o_busy,
    output logic                 o_cmd_err,
    output logic                 o_timeout,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4,
        ST_PRST = 3'd5
    } state_t;

    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_RST  = 8'h52;

    // Soft-reset length counter only needs to hold 0 .. RST_CYCLES-1.
    localparam int            PW         = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
    localparam logic [PW-1:0] PRST_LAST  = PW'(RST_CYCLES - 1);

    // Comparing the pre-increment count against MAX-1 lets the exit edge land
    // exactly on the edge where the counter reaches MAX_CYCLES.
    localparam logic [NB_CYCLES-1:0] WD_LAST = NB_CYCLES'(MAX_CYCLES - 32'd1);
    localparam logic [NB_CYCLES-1:0] CNT_SAT = {NB_CYCLES{1'b1}};

`ifdef RUN_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    state_t         state_r;
    state_t         next_state_s;
    logic [PW-1:0]  prst_cnt_r;
    logic           cmd_err_s;
    logic           count_inc_s;
    logic           set_timeout_s;
    logic           wd_hit_s;

    assign wd_hit_s = WD_EN & (o_cycle_count >= WD_LAST);

    // State register; reset lands in the power-on soft reset.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_PRST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, command acceptance and counter/watchdog requests.
    always_comb begin
        next_state_s  = state_r;
        cmd_err_s     = 1'b0;
        count_inc_s   = 1'b0;
        set_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_RUN:  next_state_s = ST_RUN;
                        CMD_STEP: next_state_s = ST_STEP;
                        CMD_RST:  next_state_s = ST_PRST;
                        default:  cmd_err_s    = 1'b1;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                count_inc_s = 1'b1;
                cmd_err_s   = i_cmd_valid && (i_cmd != CMD_HALT);
                // Program end outranks the watchdog and a halt request.
                if (i_end) begin
                    next_state_s = ST_DUMP;
                end else if (wd_hit_s) begin
                    next_state_s  = ST_DUMP;
                    set_timeout_s = 1'b1;
                end else if (i_cmd_valid && (i_cmd == CMD_HALT)) begin
                    next_state_s = ST_DUMP;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STEP: begin
                count_inc_s  = 1'b1;
                cmd_err_s    = i_cmd_valid;
                next_state_s = ST_DUMP;
            end
            ST_DUMP: begin
                cmd_err_s = i_cmd_valid;
                // o_dump_req is high only on the first DUMP cycle, so a done
                // strobe is taken no earlier than the cycle after the request.
                if (i_dump_done && !o_dump_req) begin
                    if (i_end || o_timeout) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_DUMP;
                end
            end
            ST_DONE: begin
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_RST) begin
                        next_state_s = ST_PRST;
                    end else begin
                        cmd_err_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_PRST: begin
                cmd_err_s = i_cmd_valid;
                if (prst_cnt_r == PRST_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PRST;
                end
            end
            default: begin
                next_state_s = ST_PRST;
            end
        endcase
    end

    // Soft-reset length counter; restarts from zero on every PRST entry.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            prst_cnt_r <= {PW{1'b0}};
        end else if ((state_r == ST_PRST) && (next_state_s == ST_PRST)) begin
            prst_cnt_r <= prst_cnt_r + PW'(1);
        end else begin
            prst_cnt_r <= {PW{1'b0}};
        end
    end

    // Saturating executed-cycle counter and sticky watchdog flag.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_cycle_count <= {NB_CYCLES{1'b0}};
            o_timeout     <= 1'b0;
        end else if (next_state_s == ST_PRST) begin
            o_cycle_count <= {NB_CYCLES{1'b0}};
            o_timeout     <= 1'b0;
        end else begin
            if (count_inc_s && (o_cycle_count != CNT_SAT)) begin
                o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
            end
            if (set_timeout_s) begin
                o_timeout <= 1'b1;
            end
        end
    end

    // Registered pipeline controls and status, decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_halt     <= 1'b1;
            o_pipe_rst <= 1'b1;
            o_dump_req <= 1'b0;
            o_busy     <= 1'b0;
            o_cmd_err  <= 1'b0;
            o_state    <= ST_PRST;
        end else begin
            o_halt     <= !((next_state_s == ST_RUN) || (next_state_s == ST_STEP));
            o_pipe_rst <= (next_state_s == ST_PRST);
            o_dump_req <= (next_state_s == ST_DUMP) && (state_r != ST_DUMP);
            o_busy     <= !((next_state_s == ST_IDLE) || (next_state_s == ST_DONE));
            o_cmd_err  <= cmd_err_s;
            o_state    <= next_state_s;
        end
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: a cycle-level reference model checked
// on every falling edge, plus literal expectations at key scenario points.
module tb_debug_run_ctrl;

    localparam int          RST_N   = 4;
    localparam logic [31:0] WD_MAX  = 32'd100;
    localparam longint      CNT_TOP = 64'd4294967295;
`ifdef RUN_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        end_lvl;
    logic        dump_done;
    logic        halt;
    logic        pipe_rst;
    logic        dump_req;
    logic        busy;
    logic        cmd_err;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    debug_run_ctrl #(
        .NB_CYCLES  (32),
        .MAX_CYCLES (WD_MAX),
        .RST_CYCLES (RST_N)
    ) dut (
        .clk           (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .i_end         (end_lvl),
        .i_dump_done   (dump_done),
        .o_halt        (halt),
        .o_pipe_rst    (pipe_rst),
        .o_dump_req    (dump_req),
        .o_busy        (busy),
        .o_cmd_err     (cmd_err),
        .o_timeout     (timeout),
        .o_cycle_count (cycle_count),
        .o_state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 run, 2 step, 3 dump, 4 done, 5 soft reset.
    int     m_mode;
    int     m_left;
    longint m_count;
    bit     m_timeout;
    bit     m_err;
    bit     m_first;
    bit     m_live;

    always @(posedge clk or posedge rst) begin
        int     nm;
        int     nl;
        longint nc;
        bit     nt;
        bit     ne;
        if (rst) begin
            m_mode    <= 5;
            m_left    <= RST_N;
            m_count   <= 0;
            m_timeout <= 1'b0;
            m_err     <= 1'b0;
            m_first   <= 1'b0;
            m_live    <= 1'b0;
        end else begin
            nm = m_mode; nl = m_left; nc = m_count; nt = m_timeout; ne = 1'b0;
            if ((m_mode == 1) || (m_mode == 2)) nc = (m_count == CNT_TOP) ? m_count : m_count + 1;
            case (m_mode)
                0: if (cmd_valid) begin
                       if (cmd == "C") nm = 1;
                       else if (cmd == "S") nm = 2;
                       else if (cmd == "R") nm = 5;
                       else ne = 1'b1;
                   end
                1: begin
                       if (end_lvl) nm = 3;
                       else if (WD_ON && (nc >= longint'(WD_MAX))) begin nm = 3; nt = 1'b1; end
                       else if (cmd_valid && (cmd == "H")) nm = 3;
                       ne = cmd_valid && (cmd != "H");
                   end
                2: begin nm = 3; ne = cmd_valid; end
                3: begin
                       ne = cmd_valid;
                       if (dump_done && !m_first) nm = (end_lvl || m_timeout) ? 4 : 0;
                   end
                4: if (cmd_valid) begin
                       if (cmd == "R") nm = 5;
                       else ne = 1'b1;
                   end
                5: begin
                       ne = cmd_valid;
                       nl = m_left - 1;
                       if (nl == 0) nm = 0;
                   end
                default: nm = 5;
            endcase
            if ((nm == 5) && (m_mode != 5)) begin nl = RST_N; nc = 0; nt = 1'b0; end
            m_mode    <= nm;
            m_left    <= nl;
            m_count   <= nc;
            m_timeout <= nt;
            m_err     <= ne;
            m_first   <= (nm == 3) && (m_mode != 3);
            m_live    <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",    state,       m_mode);
            chk("halt",     halt,        !((m_mode == 1) || (m_mode == 2)));
            chk("pipe_rst", pipe_rst,    m_mode == 5);
            chk("busy",     busy,        m_live && !((m_mode == 0) || (m_mode == 4)));
            chk("dump_req", dump_req,    m_first);
            chk("cmd_err",  cmd_err,     m_err);
            chk("timeout",  timeout,     m_timeout);
            chk("count",    cycle_count, 64'(m_count));
        end
    end

    // Dump requests seen during the mid-run reset window.
    bit win = 1'b0;
    int dump_seen = 0;
    always @(negedge clk) begin
        if (win && dump_req) dump_seen <= dump_seen + 1;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        cmd = b; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0; cmd = 8'h00;
    endtask

    task automatic pulse_done();
        dump_done = 1'b1;
        tick(1);
        dump_done = 1'b0;
    endtask

    task automatic soft_reset();
        send("R");
        chk("r_prst", state, 64'd5);
        tick(RST_N);
        chk("r_idle", state, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 8'h00; end_lvl = 1'b0; dump_done = 1'b0;
        tick(2);
        chk_en = 1'b1;
        chk("rst_halt", halt, 64'd1);
        chk("rst_busy", busy, 64'd0);
        tick(1);
        rst = 1'b0;
        // Power-on soft reset lasts RST_N clocks.
        chk("por_state", state, 64'd5);
        tick(3);
        chk("por_still", pipe_rst, 64'd1);
        tick(1);
        chk("por_idle", state, 64'd0);
        chk("por_prst_off", pipe_rst, 64'd0);

        // Single step.
        send("S");
        chk("step_halt", halt, 64'd0);
        tick(1);
        chk("step_dump", state, 64'd3);
        chk("step_cnt", cycle_count, 64'd1);
        chk("step_req", dump_req, 64'd1);
        tick(1);
        chk("step_req_once", dump_req, 64'd0);
        pulse_done();
        chk("step_back_idle", state, 64'd0);

        // Done strobe outside DUMP is ignored.
        pulse_done();
        chk("stray_done", state, 64'd0);
        soft_reset();

        // Run until program end after 10 cycles.
        send("C");
        chk("run_halt", halt, 64'd0);
        tick(9);
        end_lvl = 1'b1;
        tick(1);
        chk("end_cnt", cycle_count, 64'd10);
        chk("end_dump", state, 64'd3);
        tick(2);
        pulse_done();
        chk("end_done", state, 64'd4);
        send("C");
        chk("done_c_err", cmd_err, 64'd1);
        chk("done_stay", state, 64'd4);
        end_lvl = 1'b0;
        soft_reset();
        chk("r_cnt0", cycle_count, 64'd0);

        // Run, illegal 'S' mid-run, halt after 25 cycles.
        send("C");
        tick(10);
        send("S");
        chk("run_s_err", cmd_err, 64'd1);
        chk("run_s_stay", state, 64'd1);
        tick(13);
        send("H");
        chk("halt_cnt", cycle_count, 64'd25);
        tick(1);
        pulse_done();
        chk("halt_idle", state, 64'd0);
        chk("halt_no_to", timeout, 64'd0);
        soft_reset();

        // Watchdog (or its absence).
        send("C");
        if (WD_ON) begin
            for (int i = 0; i < 200; i++) begin
                if (state != 3'd1) break;
                tick(1);
            end
            chk("wd_cnt", cycle_count, 64'd100);
            chk("wd_to", timeout, 64'd1);
            tick(1);
            pulse_done();
            chk("wd_done", state, 64'd4);
        end else begin
            tick(119);
            chk("nowd_run", state, 64'd1);
            send("H");
            chk("nowd_cnt", cycle_count, 64'd120);
            chk("nowd_to", timeout, 64'd0);
            tick(1);
            pulse_done();
            chk("nowd_idle", state, 64'd0);
        end
        soft_reset();
        chk("to_cleared", timeout, 64'd0);

        // i_end and 'H' together: end wins, DONE path.
        send("C");
        tick(5);
        end_lvl = 1'b1;
        send("H");
        chk("both_dump", state, 64'd3);
        chk("both_noerr", cmd_err, 64'd0);
        tick(1);
        pulse_done();
        chk("both_done", state, 64'd4);
        end_lvl = 1'b0;
        soft_reset();

        // Unknown byte and 'H' in IDLE.
        send(8'h41);
        chk("unk_err", cmd_err, 64'd1);
        chk("unk_state", state, 64'd0);
        tick(1);
        chk("unk_err_pulse", cmd_err, 64'd0);
        send("H");
        chk("idle_h_err", cmd_err, 64'd1);

        // Asynchronous reset in the middle of a run.
        send("C");
        tick(7);
        chk("mid_cnt", cycle_count, 64'd7);
        win = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_halt", halt, 64'd1);
        chk("mid_cnt0", cycle_count, 64'd0);
        chk("mid_state", state, 64'd5);
        tick(1);
        rst = 1'b0;
        tick(RST_N + 2);
        win = 1'b0;
        chk("mid_no_dump", dump_seen, 64'd0);
        chk("mid_idle", state, 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
